id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/forward_mux.sv | 56 +++++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types and constants for the ID/EX pipeline slice.
//   CPU_XLEN           : default operand/PC width
//   ctrl_t             : packed decode control bundle (mem_read at bit 0, reg_write at bit 1)
//   fwd_sel_e          : operand source select {FWD_RF, FWD_MEM, FWD_WB}
// Consumers that take the control bundle as a plain vector index it with the
// CTRL_*_BIT constants, so the bit positions here and in ctrl_t must agree.
package cpu_pkg;

   localparam int unsigned CPU_XLEN           = 32;
   localparam int unsigned CTRL_MEM_READ_BIT  = 0;
   localparam int unsigned CTRL_REG_WRITE_BIT = 1;

   typedef struct packed {
      logic [5:0] misc;
      logic [3:0] alu_op;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       mem_write;
      logic       reg_write;
      logic       mem_read;
   } ctrl_t;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_MEM,
      FWD_WB
   } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// forward_mux -- picks one source operand from the register file or the MEM/WB bypass.
// Ports:
//   rs                         : source register index
//   rf_data                    : register-file read data for rs
//   mem_valid/mem_rd/mem_data  : result of the instruction in MEM
//   wb_valid/wb_rd/wb_data     : result of the instruction in WB
//   operand                    : selected operand
//   sel                        : which source was selected
// Bypass paths exist only when ID_EX_FORWARDING_EN is defined; otherwise the
// operand is always register-file data and hazards are resolved by stalling.
module forward_mux
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = CPU_XLEN
) (
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] operand,
   output fwd_sel_e        sel
);

`ifdef ID_EX_FORWARDING_EN
   logic mem_hit;
   logic wb_hit;

   // x0 is never bypassed: it must read as the register file's hardwired zero.
   assign mem_hit = mem_valid && (mem_rd == rs) && (rs != 5'd0);
   assign wb_hit  = wb_valid && (wb_rd == rs) && (rs != 5'd0);

   // MEM holds the younger result, so it wins over WB.
   always_comb begin
      sel     = FWD_RF;
      operand = rf_data;
      if (mem_hit) begin
         sel     = FWD_MEM;
         operand = mem_data;
      end else if (wb_hit) begin
         sel     = FWD_WB;
         operand = wb_data;
      end
   end
`else
   logic unused_fwd;

   assign sel        = FWD_RF;
   assign operand    = rf_data;
   assign unused_fwd = ^{rs, mem_valid, mem_rd, mem_data, wb_valid, wb_rd, wb_data};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- one-entry ID/EX pipeline register with operand bypass and hazard stall.
// Ports:
//   clk, rstn                        : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready                : decode-side handshake
//   in_pc, in_imm, in_rs1/2, in_rd   : decode transaction fields
//   in_ctrl                          : packed control bundle (cpu_pkg::ctrl_t layout)
//   rf_rd1, rf_rd2                   : register-file read data for in_rs1/in_rs2
//   fwd_mem_*, fwd_wb_*              : results of the instructions in MEM and WB
//   flush                            : branch redirect, kills the stage and the decode slot
//   out_ready/out_valid              : execute-side handshake
//   out_pc, out_imm, out_op1/2, out_rd, out_ctrl : registered transaction to EX
//   hazard_stall                     : decode transaction cannot issue this cycle
// Macro ID_EX_FORWARDING_EN enables the MEM/WB bypass. Without it every RAW
// dependency on EX or MEM stalls, and WB relies on the register file writing on
// the falling edge so the read in the same cycle already sees the new value.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN   = CPU_XLEN,
   parameter int unsigned CTRL_W = $bits(ctrl_t)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [XLEN-1:0]   rf_rd1,
   input  logic [XLEN-1:0]   rf_rd2,
   input  logic              fwd_mem_valid,
   input  logic [4:0]        fwd_mem_rd,
   input  logic [XLEN-1:0]   fwd_mem_data,
   input  logic              fwd_wb_valid,
   input  logic [4:0]        fwd_wb_rd,
   input  logic [XLEN-1:0]   fwd_wb_data,
   input  logic              flush,
   input  logic              out_ready,
   output logic              in_ready,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_op1,
   output logic [XLEN-1:0]   out_op2,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              hazard_stall
);

   logic              out_valid_q;
   logic [XLEN-1:0]   out_pc_q;
   logic [XLEN-1:0]   out_imm_q;
   logic [XLEN-1:0]   out_op1_q;
   logic [XLEN-1:0]   out_op2_q;
   logic [4:0]        out_rd_q;
   logic [CTRL_W-1:0] out_ctrl_q;

   logic [XLEN-1:0]   op1;
   logic [XLEN-1:0]   op2;
   fwd_sel_e          op1_sel;
   fwd_sel_e          op2_sel;
   logic              unused_sel;

   logic              load_use;
   logic              hazard_raw;
   logic              hazard;
   logic              slot_free;

   forward_mux #(
      .XLEN (XLEN)
   ) u_fwd_op1 (
      .rs        (in_rs1),
      .rf_data   (rf_rd1),
      .mem_valid (fwd_mem_valid),
      .mem_rd    (fwd_mem_rd),
      .mem_data  (fwd_mem_data),
      .wb_valid  (fwd_wb_valid),
      .wb_rd     (fwd_wb_rd),
      .wb_data   (fwd_wb_data),
      .operand   (op1),
      .sel       (op1_sel)
   );

   forward_mux #(
      .XLEN (XLEN)
   ) u_fwd_op2 (
      .rs        (in_rs2),
      .rf_data   (rf_rd2),
      .mem_valid (fwd_mem_valid),
      .mem_rd    (fwd_mem_rd),
      .mem_data  (fwd_mem_data),
      .wb_valid  (fwd_wb_valid),
      .wb_rd     (fwd_wb_rd),
      .wb_data   (fwd_wb_data),
      .operand   (op2),
      .sel       (op2_sel)
   );

   // Select codes are kept for debug visibility only.
   assign unused_sel = ^{op1_sel, op2_sel};

   // A load in the stage has no result until after MEM, so a dependent
   // instruction cannot be bypassed and must wait one cycle.
   assign load_use = out_valid_q && out_ctrl_q[CTRL_MEM_READ_BIT] && (out_rd_q != 5'd0) &&
                     ((out_rd_q == in_rs1) || (out_rd_q == in_rs2));

`ifdef ID_EX_FORWARDING_EN
   assign hazard_raw = load_use;
`else
   logic rs1_dep;
   logic rs2_dep;

   assign rs1_dep = (in_rs1 != 5'd0) &&
                    ((out_valid_q && out_ctrl_q[CTRL_REG_WRITE_BIT] && (out_rd_q == in_rs1)) ||
                     (fwd_mem_valid && (fwd_mem_rd == in_rs1)));
   assign rs2_dep = (in_rs2 != 5'd0) &&
                    ((out_valid_q && out_ctrl_q[CTRL_REG_WRITE_BIT] && (out_rd_q == in_rs2)) ||
                     (fwd_mem_valid && (fwd_mem_rd == in_rs2)));
   assign hazard_raw = load_use || rs1_dep || rs2_dep;
`endif

   assign hazard       = rstn && hazard_raw;
   assign hazard_stall = hazard;
   assign slot_free    = !out_valid_q || out_ready;

   // During flush the decode slot is accepted and silently dropped.
   always_comb begin
      in_ready = 1'b0;
      if (rstn) begin
         if (flush) begin
            in_ready = 1'b1;
         end else begin
            in_ready = slot_free && !hazard;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_imm_q   <= '0;
         out_op1_q   <= '0;
         out_op2_q   <= '0;
         out_rd_q    <= '0;
         out_ctrl_q  <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (hazard) begin
         // Bubble into EX while the decode transaction waits.
         if (slot_free) begin
            out_valid_q <= 1'b0;
         end
      end else if (slot_free) begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            out_pc_q   <= in_pc;
            out_imm_q  <= in_imm;
            out_op1_q  <= op1;
            out_op2_q  <= op2;
            out_rd_q   <= in_rd;
            out_ctrl_q <= in_ctrl;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_pc_q;
   assign out_imm   = out_imm_q;
   assign out_op1   = out_op1_q;
   assign out_op2   = out_op2_q;
   assign out_rd    = out_rd_q;
   assign out_ctrl  = out_ctrl_q;

endmodule
